// File: rtl/prm_edge_mask_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prm_edge_mask_collector                                                  |
// | Streams obstacle codes onto the checker bus, ORs the returned edge masks |
// | over a frame and emits a blocked-edge bitmap, popcount and code count.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prm_edge_mask_collector #(
  parameter int CODE_W    = 15,
  parameter int NUM_EDGES = 64,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         obs_valid,
  output logic                         obs_ready,
  input  logic [CODE_W-1:0]            obs_code,
  input  logic                         obs_last,
  output logic [CODE_W-1:0]            chk_code,
  input  logic [NUM_EDGES-1:0]         chk_mask,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NUM_EDGES-1:0]         res_mask,
  output logic [$clog2(NUM_EDGES):0]   res_blocked,
  output logic [CNT_W-1:0]             res_count
);

  localparam int BLK_W = $clog2(NUM_EDGES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [CODE_W-1:0]    chk_code_q, chk_code_d;
  logic [NUM_EDGES-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 res_valid_q, res_valid_d;
  logic [NUM_EDGES-1:0] res_mask_q, res_mask_d;
  logic [BLK_W-1:0]     res_blocked_q, res_blocked_d;
  logic [CNT_W-1:0]     res_count_q, res_count_d;

  logic                 hs;
  logic [NUM_EDGES-1:0] fold;

  function automatic logic [BLK_W-1:0] popcnt(input logic [NUM_EDGES-1:0] v);
    logic [BLK_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_EDGES; i++) begin
      n = n + {{(BLK_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Ready is registered so it stays low through reset; clear masks it in-cycle.
  assign obs_ready = rdy_q & ~clear;
  assign hs        = obs_valid & obs_ready;
  assign fold      = acc_q | chk_mask;

  always_comb begin
    state_d       = state_q;
    s1_vld_d      = 1'b0;
    chk_code_d    = chk_code_q;
    acc_d         = acc_q;
    count_d       = count_q;
    res_valid_d   = res_valid_q;
    res_mask_d    = res_mask_q;
    res_blocked_d = res_blocked_q;
    res_count_d   = res_count_q;

    case (state_q)
      ST_RUN: begin
        if (s1_vld_q) begin
          acc_d = fold;
        end
        if (hs) begin
          chk_code_d = obs_code;
          s1_vld_d   = 1'b1;
          count_d    = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
          if (obs_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        res_mask_d    = fold;
        res_blocked_d = popcnt(fold);
        res_count_d   = count_q;
        res_valid_d   = 1'b1;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Abort wins over everything, including a result about to be published.
    if (clear) begin
      acc_d       = '0;
      count_d     = '0;
      s1_vld_d    = 1'b0;
      res_valid_d = 1'b0;
      state_d     = ST_RUN;
    end

    rdy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      rdy_q         <= 1'b0;
      s1_vld_q      <= 1'b0;
      chk_code_q    <= '0;
      acc_q         <= '0;
      count_q       <= '0;
      res_valid_q   <= 1'b0;
      res_mask_q    <= '0;
      res_blocked_q <= '0;
      res_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      s1_vld_q      <= s1_vld_d;
      chk_code_q    <= chk_code_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      res_valid_q   <= res_valid_d;
      res_mask_q    <= res_mask_d;
      res_blocked_q <= res_blocked_d;
      res_count_q   <= res_count_d;
    end
  end

  assign chk_code    = chk_code_q;
  assign res_valid   = res_valid_q;
  assign res_mask    = res_mask_q;
  assign res_blocked = res_blocked_q;
  assign res_count   = res_count_q;

endmodule
`default_nettype wire
